// File: rtl/tx_8b10b_pkg.sv
// Shared definitions for the 8b/10b transmit path: control-symbol byte values
// and the frame sequencer state encoding.
package tx_8b10b_pkg;

  localparam logic [7:0] SYM_K28_5 = 8'hBC;  // comma, idle fill and training
  localparam logic [7:0] SYM_K28_0 = 8'h1C;  // clock-compensation skip
  localparam logic [7:0] SYM_SOP   = 8'hFB;  // K27.7
  localparam logic [7:0] SYM_EOP   = 8'hFD;  // K29.7
  localparam logic [7:0] SYM_ABORT = 8'hFE;  // K30.7

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    TRAIN = 3'd1,
    IDLE  = 3'd2,
    DATA  = 3'd3,
    EOP   = 3'd4,
    DRAIN = 3'd5
  } tx_state_t;

endpackage

// File: rtl/tx_frame_sequencer.sv
// Drives K/ebi into the 8b/10b encoder once per SBYTECLK: comma training,
// idle fill with periodic skips, and SOP/data/EOP framing with abort on error.
module tx_frame_sequencer
  import tx_8b10b_pkg::*;
#(
  parameter int TRAIN_LEN     = 16,
  parameter int SKIP_INTERVAL = 64,
  parameter int MAX_PKT_LEN   = 256,
  parameter int LEN_W         = 9
) (
  input  logic       SBYTECLK,
  input  logic       reset,
  input  logic       enable,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  output logic       pkt_ready,
  output logic       K,
  output logic [7:0] ebi,
  output logic       link_up,
  output logic [7:0] abort_cnt
);

  localparam int TRAIN_W = $clog2(TRAIN_LEN + 1);
  localparam int SKIP_W  = $clog2(SKIP_INTERVAL);

  tx_state_t          r_state;
  logic [TRAIN_W-1:0] r_train_cnt;
  logic [SKIP_W-1:0]  r_skip_cnt;
  logic [LEN_W-1:0]   r_byte_cnt;
  logic               r_gap;
  logic               r_k;
  logic [7:0]         r_ebi;
  logic               r_link_up;
  logic [7:0]         r_abort_cnt;

  tx_state_t          w_state_nxt;
  logic [TRAIN_W-1:0] w_train_nxt;
  logic [SKIP_W-1:0]  w_skip_nxt;
  logic [LEN_W-1:0]   w_byte_nxt;
  logic               w_gap_nxt;
  logic               w_k_nxt;
  logic [7:0]         w_ebi_nxt;
  logic               w_link_nxt;
  logic               w_abort_inc;

  assign pkt_ready = (r_state == DATA) || (r_state == DRAIN);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through the case leaves a latch.
    w_state_nxt = r_state;
    w_train_nxt = r_train_cnt;
    w_skip_nxt  = r_skip_cnt;
    w_byte_nxt  = r_byte_cnt;
    w_gap_nxt   = r_gap;
    w_k_nxt     = 1'b1;
    w_ebi_nxt   = SYM_K28_5;
    w_link_nxt  = 1'b1;
    w_abort_inc = 1'b0;

    case (r_state)
      OFF: begin
        w_link_nxt = 1'b0;
        if (enable) begin
          w_state_nxt = TRAIN;
          w_train_nxt = '0;
          w_skip_nxt  = '0;
        end
      end

      TRAIN: begin
        // link_up rises with the first symbol IDLE emits, not with the last comma
        w_link_nxt = 1'b0;
        if (!enable) begin
          w_state_nxt = OFF;
        end else if (r_train_cnt == TRAIN_W'(TRAIN_LEN - 1)) begin
          w_state_nxt = IDLE;
          w_skip_nxt  = '0;
          w_gap_nxt   = 1'b0;
        end else begin
          w_train_nxt = r_train_cnt + 1'b1;
        end
      end

      IDLE: begin
        w_gap_nxt = 1'b0;
        if (!enable) begin
          w_state_nxt = OFF;
          w_link_nxt  = 1'b0;
        end else if (r_skip_cnt == SKIP_W'(SKIP_INTERVAL - 1)) begin
          w_ebi_nxt  = SYM_K28_0;
          w_skip_nxt = '0;
        end else if (pkt_valid && !r_gap) begin
          w_ebi_nxt   = SYM_SOP;
          w_state_nxt = DATA;
          w_byte_nxt  = '0;
        end else begin
          w_skip_nxt = r_skip_cnt + 1'b1;
        end
      end

      DATA: begin
        if (pkt_valid) begin
          if (r_byte_cnt < LEN_W'(MAX_PKT_LEN)) begin
            w_k_nxt    = 1'b0;
            w_ebi_nxt  = pkt_data;
            w_byte_nxt = r_byte_cnt + 1'b1;
            if (pkt_last) w_state_nxt = EOP;
          end else begin
            w_ebi_nxt   = SYM_ABORT;
            w_abort_inc = 1'b1;
            w_state_nxt = pkt_last ? IDLE : DRAIN;
          end
        end else begin
          w_ebi_nxt   = SYM_ABORT;
          w_abort_inc = 1'b1;
          w_state_nxt = DRAIN;
        end
      end

      EOP: begin
        // forces at least one idle-class symbol before the next SOP
        w_ebi_nxt   = SYM_EOP;
        w_state_nxt = IDLE;
        w_gap_nxt   = 1'b1;
      end

      DRAIN: begin
        if (pkt_valid && pkt_last) w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = OFF;
        w_link_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SBYTECLK) begin
    if (reset) begin
      r_state     <= OFF;
      r_train_cnt <= '0;
      r_skip_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_gap       <= 1'b0;
      r_k         <= 1'b1;
      r_ebi       <= SYM_K28_5;
      r_link_up   <= 1'b0;
      r_abort_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_train_cnt <= w_train_nxt;
      r_skip_cnt  <= w_skip_nxt;
      r_byte_cnt  <= w_byte_nxt;
      r_gap       <= w_gap_nxt;
      r_k         <= w_k_nxt;
      r_ebi       <= w_ebi_nxt;
      r_link_up   <= w_link_nxt;
      if (w_abort_inc && (r_abort_cnt != 8'hFF)) r_abort_cnt <= r_abort_cnt + 1'b1;
    end
  end

  assign K         = r_k;
  assign ebi       = r_ebi;
  assign link_up   = r_link_up;
  assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer: the driver queues the expected
// symbol for every clock, a monitor pops and compares after each edge.
module tb_tx_frame_sequencer;

  localparam logic [7:0] BC  = 8'hBC;
  localparam logic [7:0] SK  = 8'h1C;
  localparam logic [7:0] SOP = 8'hFB;
  localparam logic [7:0] EOP = 8'hFD;
  localparam logic [7:0] AB  = 8'hFE;

  typedef struct packed {
    logic       k;
    logic [7:0] ebi;
    logic       link;
    logic       rdy;
    logic [7:0] ab;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_last;
  logic       pkt_ready;
  logic       K;
  logic [7:0] ebi;
  logic       link_up;
  logic [7:0] abort_cnt;

  exp_t       sb[$];
  logic [7:0] exp_abort = 8'h00;
  int         checks    = 0;
  int         failures  = 0;
  int         idx       = 0;

  always #5 clk = ~clk;

  tx_frame_sequencer #(
    .TRAIN_LEN    (16),
    .SKIP_INTERVAL(64),
    .MAX_PKT_LEN  (4),
    .LEN_W        (9)
  ) dut (
    .SBYTECLK (clk),
    .reset    (reset),
    .enable   (enable),
    .pkt_valid(pkt_valid),
    .pkt_data (pkt_data),
    .pkt_last (pkt_last),
    .pkt_ready(pkt_ready),
    .K        (K),
    .ebi      (ebi),
    .link_up  (link_up),
    .abort_cnt(abort_cnt)
  );

  task automatic check(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got K=%b ebi=%h link=%b rdy=%b abort=%h, want K=%b ebi=%h link=%b rdy=%b abort=%h",
               name, act.k, act.ebi, act.link, act.rdy, act.ab,
               exp.k, exp.ebi, exp.link, exp.rdy, exp.ab);
    end
  endtask

  // One clock of stimulus plus the output expected right after that edge.
  task automatic step(input logic rst, input logic en, input logic v, input logic [7:0] d,
                      input logic l, input logic ek, input logic [7:0] ee,
                      input logic el, input logic er);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    enable    = en;
    pkt_valid = v;
    pkt_data  = d;
    pkt_last  = l;
    e = '{k: ek, ebi: ee, link: el, rdy: er, ab: exp_abort};
    sb.push_back(e);
  endtask

  task automatic lk(input logic v, input logic [7:0] d, input logic l,
                    input logic ek, input logic [7:0] ee, input logic er);
    step(1'b0, 1'b1, v, d, l, ek, ee, 1'b1, er);
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        a = '{k: K, ebi: ebi, link: link_up, rdy: pkt_ready, ab: abort_cnt};
        check($sformatf("sym%0d", idx), a, e);
        idx++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; enable = 1'b0; pkt_valid = 1'b0; pkt_data = 8'h00; pkt_last = 1'b0;

    // reset, then bring-up: one OFF comma plus 16 training commas
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, BC, 1'b0, 1'b0);
    repeat (17) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, BC, 1'b0, 1'b0);

    // idle fill: every 64th symbol is a skip
    for (int i = 0; i < 128; i++) lk(1'b0, 8'h00, 1'b0, 1'b1, (i % 64 == 63) ? SK : BC, 1'b0);

    // nominal 3-byte packet
    lk(1'b1, 8'h11, 1'b0, 1'b1, SOP,   1'b1);
    lk(1'b1, 8'h11, 1'b0, 1'b0, 8'h11, 1'b1);
    lk(1'b1, 8'h22, 1'b0, 1'b0, 8'h22, 1'b1);
    lk(1'b1, 8'h33, 1'b1, 1'b0, 8'h33, 1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, EOP,   1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, BC,    1'b0);

    // back-to-back single-byte packets with a forced idle gap
    lk(1'b1, 8'hA5, 1'b1, 1'b1, SOP,   1'b1);
    lk(1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0);
    lk(1'b1, 8'h5A, 1'b1, 1'b1, EOP,   1'b0);
    lk(1'b1, 8'h5A, 1'b1, 1'b1, BC,    1'b0);
    lk(1'b1, 8'h5A, 1'b1, 1'b1, SOP,   1'b1);
    lk(1'b1, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, EOP,   1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, BC,    1'b0);

    // underrun after byte 22, rest drained
    lk(1'b1, 8'h11, 1'b0, 1'b1, SOP,   1'b1);
    lk(1'b1, 8'h11, 1'b0, 1'b0, 8'h11, 1'b1);
    lk(1'b1, 8'h22, 1'b0, 1'b0, 8'h22, 1'b1);
    exp_abort = 8'd1;
    lk(1'b0, 8'h00, 1'b0, 1'b1, AB,    1'b1);
    lk(1'b1, 8'h33, 1'b0, 1'b1, BC,    1'b1);
    lk(1'b1, 8'h44, 1'b1, 1'b1, BC,    1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, BC,    1'b0);

    // oversize: 6 bytes against a 4-byte limit
    lk(1'b1, 8'h01, 1'b0, 1'b1, SOP,   1'b1);
    for (int b = 1; b <= 4; b++) lk(1'b1, 8'(b), 1'b0, 1'b0, 8'(b), 1'b1);
    exp_abort = 8'd2;
    lk(1'b1, 8'h05, 1'b0, 1'b1, AB,    1'b1);
    lk(1'b1, 8'h06, 1'b1, 1'b1, BC,    1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, BC,    1'b0);

    // exactly MAX_PKT_LEN bytes is a normal packet
    lk(1'b1, 8'h01, 1'b0, 1'b1, SOP,   1'b1);
    for (int b = 1; b <= 3; b++) lk(1'b1, 8'(b), 1'b0, 1'b0, 8'(b), 1'b1);
    lk(1'b1, 8'h04, 1'b1, 1'b0, 8'h04, 1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, EOP,   1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, BC,    1'b0);

    // MAX_PKT_LEN+1 bytes with last on the extra byte: abort straight to idle
    lk(1'b1, 8'h01, 1'b0, 1'b1, SOP,   1'b1);
    for (int b = 1; b <= 4; b++) lk(1'b1, 8'(b), 1'b0, 1'b0, 8'(b), 1'b1);
    exp_abort = 8'd3;
    lk(1'b1, 8'h05, 1'b1, 1'b1, AB,    1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, BC,    1'b0);

    // skip count now 7: run it up to 63, then skip wins over a pending packet
    repeat (56) lk(1'b0, 8'h00, 1'b0, 1'b1, BC, 1'b0);
    lk(1'b1, 8'h77, 1'b1, 1'b1, SK,    1'b0);
    lk(1'b1, 8'h77, 1'b1, 1'b1, SOP,   1'b1);
    lk(1'b1, 8'h77, 1'b1, 1'b0, 8'h77, 1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, EOP,   1'b0);
    lk(1'b0, 8'h00, 1'b0, 1'b1, BC,    1'b0);

    // synchronous reset in the middle of a packet
    lk(1'b1, 8'h88, 1'b0, 1'b1, SOP,   1'b1);
    lk(1'b1, 8'h88, 1'b0, 1'b0, 8'h88, 1'b1);
    exp_abort = 8'd0;
    step(1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b1, BC, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, BC, 1'b0, 1'b0);

    // enable dropped during training, then full retrain and drop from idle
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, BC, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, BC, 1'b0, 1'b0);
    repeat (17) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, BC, 1'b0, 1'b0);
    repeat (2) lk(1'b0, 8'h00, 1'b0, 1'b1, BC, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, BC, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
